binarize_stream_packer: RTL and testbench

//  Streaming successor to the single-pixel binarizer at the front of the BNN FCC datapath.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/bnn_threshold_cmp.sv | 17 +
 rtl/binarize_stream_packer.sv | 114 +++++++++++
 tb/tb_binarize_stream_packer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN front-end: pixel width, packer state encoding and
// the width helper for packed-word bit counts.
package bnn_pkg;

   localparam int unsigned PIXEL_WIDTH = 8;

   typedef enum logic {
      StFill = 1'b0,
      StHold = 1'b1
   } pack_state_e;

   // Bits needed to hold a count of 0..word_bits valid bits.
   function automatic int unsigned count_width(input int unsigned word_bits);
      return $clog2(word_bits + 1);
   endfunction

endpackage

// File: rtl/bnn_threshold_cmp.sv
// Single-pixel threshold comparator: above = (pixel >= threshold), signed or unsigned.
module bnn_threshold_cmp #(
   parameter int unsigned W      = 8,
   parameter bit          SIGNED = 1'b0
) (
   input  logic [W-1:0] pixel,
   input  logic [W-1:0] threshold,
   output logic         above
);

   if (SIGNED) begin : g_signed
      always_comb above = ($signed(pixel) >= $signed(threshold));
   end else begin : g_unsigned
      always_comb above = (pixel >= threshold);
   end

endmodule

// File: rtl/binarize_stream_packer.sv
// Streaming binarizer: thresholds PIXELS_PER_BEAT pixels per beat and packs the result
// bits LSB-first into OUTPUT_WIDTH-bit words, flushing a zero-padded short word on in_last.
module binarize_stream_packer
   import bnn_pkg::*;
#(
   parameter int unsigned INPUT_DATA_WIDTH = PIXEL_WIDTH,
   parameter int unsigned PIXELS_PER_BEAT  = 8,
   parameter int unsigned OUTPUT_WIDTH     = 64,
   parameter bit          SIGNED_INPUT     = 1'b0
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [INPUT_DATA_WIDTH-1:0]                 cfg_threshold,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [PIXELS_PER_BEAT*INPUT_DATA_WIDTH-1:0] in_data,
   input  logic                                        in_last,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [OUTPUT_WIDTH-1:0]                     out_data,
   output logic                                        out_last,
   output logic [count_width(OUTPUT_WIDTH)-1:0]        out_count
);

   localparam int unsigned BPW     = OUTPUT_WIDTH / PIXELS_PER_BEAT;
   localparam int unsigned CNT_W   = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned COUNT_W = count_width(OUTPUT_WIDTH);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BPW - 1);

   if ((OUTPUT_WIDTH % PIXELS_PER_BEAT) != 0) begin : g_bad_width
      $error("OUTPUT_WIDTH must be a multiple of PIXELS_PER_BEAT");
   end

   logic [PIXELS_PER_BEAT-1:0] beat_bits;
   logic [OUTPUT_WIDTH-1:0]    acc;
   logic [OUTPUT_WIDTH-1:0]    word_merged;
   logic [CNT_W-1:0]           beat_cnt;
   logic [COUNT_W-1:0]         count_next;
   logic                       word_end;
   logic                       accept;
   logic                       complete;
   pack_state_e                state, state_next;

   for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_cmp
      bnn_threshold_cmp #(
         .W      (INPUT_DATA_WIDTH),
         .SIGNED (SIGNED_INPUT)
      ) u_cmp (
         .pixel     (in_data[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]),
         .threshold (cfg_threshold),
         .above     (beat_bits[i])
      );
   end

   // A held word only blocks beats that would complete the next word.
   assign word_end = (beat_cnt == LAST_SLOT) || in_last;
   assign in_ready = !out_valid || out_ready || !word_end;
   assign accept   = in_valid && in_ready;
   assign complete = accept && word_end;

   always_comb begin
      word_merged = acc;
      for (int unsigned b = 0; b < BPW; b++) begin
         if (beat_cnt == CNT_W'(b)) begin
            word_merged[b*PIXELS_PER_BEAT +: PIXELS_PER_BEAT] = beat_bits;
         end
      end
   end

   assign count_next = COUNT_W'((32'(beat_cnt) + 32'd1) * PIXELS_PER_BEAT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= StFill;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         StFill:  if (complete) state_next = StHold;
         StHold:  if (!complete && out_ready) state_next = StFill;
         default: state_next = StFill;
      endcase
   end

   always_comb begin
      out_valid = (state == StHold);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         beat_cnt  <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_count <= '0;
      end else if (accept) begin
         if (word_end) begin
            out_data  <= word_merged;
            out_count <= count_next;
            out_last  <= in_last;
            acc       <= '0;
            beat_cnt  <= '0;
         end else begin
            acc      <= word_merged;
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_binarize_stream_packer.sv
// Bench for binarize_stream_packer (8 pixels/beat, 32-bit words): scoreboard of expected
// words built from thresholded pixels, plus a signed-mode instance.
module tb_binarize_stream_packer;

   typedef struct packed {
      logic [31:0] data;
      logic [5:0]  count;
      logic        last;
   } word_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  cfg_threshold = 8'd128;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_last;
   logic [5:0]  out_count;

   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [63:0] s_in_data = '0;
   logic        s_in_last = 1'b0;
   logic        s_out_valid;
   logic [31:0] s_out_data;
   logic        s_out_last;
   logic [5:0]  s_out_count;

   int compared = 0;
   int failed   = 0;

   word_t       exp_q[$];
   logic [31:0] m_acc = '0;
   int          m_cnt = 0;
   word_t       mon_got;
   word_t       mon_exp;

   always #5 clk = ~clk;

   binarize_stream_packer #(
      .INPUT_DATA_WIDTH (8),
      .PIXELS_PER_BEAT  (8),
      .OUTPUT_WIDTH     (32),
      .SIGNED_INPUT     (1'b0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_threshold (cfg_threshold),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .out_count     (out_count)
   );

   binarize_stream_packer #(
      .INPUT_DATA_WIDTH (8),
      .PIXELS_PER_BEAT  (8),
      .OUTPUT_WIDTH     (32),
      .SIGNED_INPUT     (1'b1)
   ) dut_signed (
      .clk           (clk),
      .rst           (rst),
      .cfg_threshold (8'h00),
      .in_valid      (s_in_valid),
      .in_ready      (s_in_ready),
      .in_data       (s_in_data),
      .in_last       (s_in_last),
      .out_valid     (s_out_valid),
      .out_ready     (1'b1),
      .out_data      (s_out_data),
      .out_last      (s_out_last),
      .out_count     (s_out_count)
   );

   function automatic void model_beat(input logic [63:0] data, input logic last);
      for (int i = 0; i < 8; i++) begin
         m_acc[m_cnt*8 + i] = (data[i*8 +: 8] >= cfg_threshold);
      end
      m_cnt++;
      if (m_cnt == 4 || last) begin
         exp_q.push_back({m_acc, 6'(m_cnt * 8), last});
         m_acc = '0;
         m_cnt = 0;
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      m_acc = '0;
      m_cnt = 0;
   endfunction

   // Word handshakes complete on the following posedge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         compared++;
         mon_got = {out_data, out_count, out_last};
         if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL word_unexpected: got data=%h count=%0d last=%b, required no word",
                     out_data, out_count, out_last);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               failed++;
               $display("FAIL word: got data=%h count=%0d last=%b, required data=%h count=%0d last=%b",
                        out_data, out_count, out_last, mon_exp.data, mon_exp.count, mon_exp.last);
            end
         end
      end
   end

   // Called and returns at #1 after a posedge; leaves in_valid high for back-to-back beats.
   task automatic send_beat(input logic [63:0] data, input logic last, output int waited);
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      compared++;
      if (!in_ready) begin
         failed++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      end else begin
         model_beat(data, last);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      #3;
      compared++;
      if ({out_valid, out_data, out_count, out_last} !== 40'd0) begin
         failed++;
         $display("FAIL reset_state: got valid=%b data=%h count=%0d last=%b, required all 0",
                  out_valid, out_data, out_count, out_last);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      compared++;
      if (in_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_full_word();
      int w;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         compared++;
         if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL full_early_valid: beat %0d got out_valid=%b, required 0", k, out_valid);
         end
         send_beat(64'hFFFF_FFFF_FFFF_FFFF, (k == 3), w);
      end
      idle_in();
      compared++;
      if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFF || out_count !== 6'd32
          || out_last !== 1'b1) begin
         failed++;
         $display("FAIL full_latency: got valid=%b data=%h count=%0d last=%b, required 1 ffffffff 32 1",
                  out_valid, out_data, out_count, out_last);
      end
      wait_drain();
      compared++;
      if (exp_q.size() != 0) begin
         failed++;
         $display("FAIL full_drain: got %0d pending words, required 0", exp_q.size());
      end
   endtask

   task automatic test_pattern();
      int w;
      // pixel0 = 127 at the LSB byte
      send_beat({8'd128, 8'd200, 8'd1, 8'd129, 8'd255, 8'd0, 8'd128, 8'd127}, 1'b1, w);
      idle_in();
      compared++;
      if (out_data[7:0] !== 8'hDA || out_count !== 6'd8 || out_valid !== 1'b1) begin
         failed++;
         $display("FAIL pattern_bits: got bits=%h count=%0d valid=%b, required da 8 1",
                  out_data[7:0], out_count, out_valid);
      end
      wait_drain();
   endtask

   task automatic test_short_last();
      int w;
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
      compared++;
      if (out_data !== 32'h0000_FFFF || out_count !== 6'd16 || out_last !== 1'b1) begin
         failed++;
         $display("FAIL short_word: got data=%h count=%0d last=%b, required 0000ffff 16 1",
                  out_data, out_count, out_last);
      end
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
      send_beat(64'h0000_0000_0000_0000, 1'b0, w);
      send_beat(64'h0000_0000_FFFF_FFFF, 1'b0, w);
      send_beat(64'h0000_0000_0000_0000, 1'b0, w);
      idle_in();
      compared++;
      if (out_data !== 32'h000F_00FF || out_count !== 6'd32 || out_last !== 1'b0) begin
         failed++;
         $display("FAIL short_next_word: got data=%h count=%0d last=%b, required 000f00ff 32 0",
                  out_data, out_count, out_last);
      end
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int w;
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         send_beat({$urandom, $urandom}, (k == 5 || k == 11), w);
         compared++;
         if (w != 0) begin
            failed++;
            $display("FAIL b2b_stall: beat %0d waited %0d cycles, required 0", k, w);
         end
      end
      idle_in();
      wait_drain();
      compared++;
      if (exp_q.size() != 0) begin
         failed++;
         $display("FAIL b2b_drain: got %0d pending words, required 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int          w;
      int          w8;
      logic [63:0] beats[8];
      word_t       held;
      for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
      out_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
         send_beat(beats[k], 1'b0, w);
         compared++;
         if (w != 0) begin
            failed++;
            $display("FAIL bp_early_stall: beat %0d waited %0d cycles, required 0", k, w);
         end
      end
      held = exp_q[0];
      fork
         send_beat(beats[7], 1'b0, w8);
         begin
            repeat (10) begin
               @(negedge clk);
               compared++;
               if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held.data
                   || out_count !== held.count) begin
                  failed++;
                  $display("FAIL bp_hold: got ready=%b valid=%b data=%h count=%0d, required 0 1 %h %0d",
                           in_ready, out_valid, out_data, out_count, held.data, held.count);
               end
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      idle_in();
      compared++;
      if (out_valid !== 1'b1 || exp_q.size() != 1) begin
         failed++;
         $display("FAIL bp_no_bubble: got valid=%b pending=%0d, required 1 1", out_valid, exp_q.size());
      end
      wait_drain();
   endtask

   task automatic test_async_reset();
      int w;
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
      idle_in();
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      compared++;
      if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1) begin
         failed++;
         $display("FAIL async_reset: got valid=%b data=%h ready=%b, required 0 00000000 1",
                  out_valid, out_data, in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send_beat(64'h0000_0000_0000_0000, 1'b0, w);
      send_beat(64'h0000_0000_0000_0000, 1'b0, w);
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
      idle_in();
      compared++;
      if (out_data !== 32'hFFFF_0000 || out_count !== 6'd32) begin
         failed++;
         $display("FAIL fresh_word: got data=%h count=%0d, required ffff0000 32", out_data, out_count);
      end
      wait_drain();
   endtask

   task automatic test_signed();
      int n = 0;
      s_in_valid = 1'b1;
      s_in_last  = 1'b1;
      s_in_data  = {8'hC0, 8'h40, 8'hFE, 8'h01, 8'h7F, 8'h00, 8'hFF, 8'h80};
      @(negedge clk);
      while (!s_in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      s_in_last  = 1'b0;
      compared++;
      if (s_out_valid !== 1'b1 || s_out_data[7:0] !== 8'h5C || s_out_count !== 6'd8
          || s_out_last !== 1'b1) begin
         failed++;
         $display("FAIL signed_bits: got valid=%b bits=%h count=%0d last=%b, required 1 5c 8 1",
                  s_out_valid, s_out_data[7:0], s_out_count, s_out_last);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_word();
      test_pattern();
      test_short_last();
      test_back_to_back();
      test_backpressure();
      test_async_reset();
      test_signed();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
